// File: rtl/axi_node_pkg.sv
// Shared AXI node types: the per-AW routing record kept by the W steering logic.
package axi_node_pkg;
  localparam int AXI_LEN_W       = 8;
  localparam int NODE_N_MASTER   = 5;
  localparam int NODE_LOG_MASTER = (NODE_N_MASTER > 1) ? $clog2(NODE_N_MASTER) : 1;

  typedef struct packed {
    logic [NODE_LOG_MASTER-1:0] sel;
    logic [AXI_LEN_W-1:0]       len;
  } aw_route_t;
endpackage

// File: rtl/axi_route_fifo.sv
// Generic in-order FIFO; pointers carry one extra wrap bit so full/empty need no counter.
module axi_route_fifo #(
  parameter type entry_t = logic [7:0],
  parameter int  DEPTH   = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_i,
  input  entry_t data_i,
  input  logic   pop_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];

  assign full_o  = (wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}};
  assign empty_o = wptr_q == rptr_q;
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mem_d  = mem_q;
    // A full FIFO refuses the push even when a pop happens in the same cycle.
    if (push_i && !full_o) begin
      mem_d[wptr_q[AW-1:0]] = data_i;
      wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (pop_i && !empty_o) begin
      rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
    mem_q <= mem_d;
  end
endmodule

// File: rtl/axi_aw_w_steer.sv
// Records each granted AW's master/length and steers that master's W beats to the slave
// in AW order, flagging bursts whose WLAST disagrees with AWLEN.
module axi_aw_w_steer
  import axi_node_pkg::*;
#(
  parameter int N_MASTER   = NODE_N_MASTER,
  parameter int LOG_MASTER = (N_MASTER > 1) ? $clog2(N_MASTER) : 1,
  parameter int W_WIDTH    = 64,
  parameter int DEPTH      = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               aw_req_i,
  input  logic [LOG_MASTER-1:0]              aw_sel_i,
  input  logic [AXI_LEN_W-1:0]               aw_len_i,
  output logic                               aw_gnt_o,
  output logic                               aw_req_o,
  input  logic                               aw_gnt_i,
  input  logic [N_MASTER-1:0]                w_valid_i,
  input  logic [N_MASTER-1:0]                w_last_i,
  input  logic [N_MASTER-1:0][W_WIDTH-1:0]   w_data_i,
  output logic [N_MASTER-1:0]                w_ready_o,
  output logic                               w_valid_o,
  output logic                               w_last_o,
  output logic [W_WIDTH-1:0]                 w_data_o,
  input  logic                               w_ready_i,
  output logic                               full_o,
  output logic                               len_err_o
);
  logic                  full, empty, push, pop, w_hs;
  aw_route_t             push_entry, head;
  logic [LOG_MASTER-1:0] m;
  logic [AXI_LEN_W-1:0]  beat_q, beat_d;
  logic                  len_err_q, len_err_d;

  // Full comes straight from registered pointers, so a W pop never reaches the AW grant.
  assign aw_req_o   = aw_req_i & ~full;
  assign aw_gnt_o   = aw_gnt_i & ~full;
  assign push       = aw_req_o & aw_gnt_i;
  assign push_entry = '{sel: aw_sel_i, len: aw_len_i};
  assign full_o     = full;
  assign len_err_o  = len_err_q;

  axi_route_fifo #(
    .entry_t (aw_route_t),
    .DEPTH   (DEPTH)
  ) u_route_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    m         = (N_MASTER == 1) ? '0 : head.sel;
    w_valid_o = 1'b0;
    w_last_o  = 1'b0;
    w_data_o  = '0;
    w_ready_o = '0;
    if (!empty && (int'(m) < N_MASTER)) begin
      w_valid_o    = w_valid_i[m];
      w_last_o     = w_last_i[m];
      w_data_o     = w_data_i[m];
      w_ready_o[m] = w_ready_i;
    end
  end

  assign w_hs = w_valid_o & w_ready_i;
  assign pop  = w_hs & w_last_o;

  always_comb begin
    beat_d    = beat_q;
    len_err_d = 1'b0;
    if (w_hs) begin
      // Early WLAST and a missing WLAST on the final counted beat both flag; the burst
      // still only retires on WLAST.
      len_err_d = w_last_o ? (beat_q != head.len) : (beat_q == head.len);
      beat_d    = w_last_o ? '0 : beat_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q    <= '0;
      len_err_q <= 1'b0;
    end else begin
      beat_q    <= beat_d;
      len_err_q <= len_err_d;
    end
  end
endmodule

// File: tb/tb_axi_aw_w_steer.sv
// Randomized and directed bench for axi_aw_w_steer against a queue-based reference model.
module tb_axi_aw_w_steer;
  localparam int NM = 5;
  localparam int WW = 64;
  localparam int DP = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              aw_req_i = 1'b0;
  logic [2:0]        aw_sel_i = '0;
  logic [7:0]        aw_len_i = '0;
  logic              aw_gnt_o, aw_req_o;
  logic              aw_gnt_i = 1'b0;
  logic [NM-1:0]     w_valid_i = '0;
  logic [NM-1:0]     w_last_i = '0;
  logic [NM-1:0][WW-1:0] w_data_i = '0;
  logic [NM-1:0]     w_ready_o;
  logic              w_valid_o, w_last_o;
  logic [WW-1:0]     w_data_o;
  logic              w_ready_i = 1'b0;
  logic              full_o, len_err_o;

  axi_aw_w_steer #(.N_MASTER(NM), .W_WIDTH(WW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst),
    .aw_req_i(aw_req_i), .aw_sel_i(aw_sel_i), .aw_len_i(aw_len_i),
    .aw_gnt_o(aw_gnt_o), .aw_req_o(aw_req_o), .aw_gnt_i(aw_gnt_i),
    .w_valid_i(w_valid_i), .w_last_i(w_last_i), .w_data_i(w_data_i),
    .w_ready_o(w_ready_o), .w_valid_o(w_valid_o), .w_last_o(w_last_o),
    .w_data_o(w_data_o), .w_ready_i(w_ready_i),
    .full_o(full_o), .len_err_o(len_err_o)
  );

  always #5 clk = ~clk;

  typedef struct { int sel; int len; } route_t;
  route_t q[$];
  int     beat_m = 0;
  bit     err_m  = 1'b0;
  int     total  = 0;
  int     bad    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive after the falling edge, compare, then advance the model at the rising edge.
  task automatic cycle(input bit r, input bit areq, input int asel, input int alen, input bit agnt,
                       input logic [NM-1:0] wv, input logic [NM-1:0] wl, input bit wr);
    logic [WW-1:0]  dat [NM];
    bit             full_e, emp, v_e, l_e, hs;
    logic [WW-1:0]  d_e;
    logic [NM-1:0]  rdy_e;
    @(negedge clk);
    rst = r; aw_req_i = areq; aw_sel_i = 3'(asel); aw_len_i = 8'(alen); aw_gnt_i = agnt;
    w_valid_i = wv; w_last_i = wl; w_ready_i = wr;
    for (int i = 0; i < NM; i++) begin
      dat[i] = {$urandom, $urandom};
      w_data_i[i] = dat[i];
    end
    #1;
    full_e = (q.size() == DP);
    emp    = (q.size() == 0);
    v_e = 0; l_e = 0; d_e = '0; rdy_e = '0;
    if (!emp) begin
      v_e = wv[q[0].sel]; l_e = wl[q[0].sel]; d_e = dat[q[0].sel]; rdy_e[q[0].sel] = wr;
    end
    check("full_o",    full_o,    full_e);
    check("aw_req_o",  aw_req_o,  areq && !full_e);
    check("aw_gnt_o",  aw_gnt_o,  agnt && !full_e);
    check("w_valid_o", w_valid_o, v_e);
    check("w_last_o",  w_last_o,  l_e);
    check("w_data_o",  w_data_o,  d_e);
    check("w_ready_o", w_ready_o, rdy_e);
    check("len_err_o", len_err_o, err_m);
    hs = v_e && wr;
    @(posedge clk);
    if (r) begin
      q.delete(); beat_m = 0; err_m = 0;
    end else begin
      err_m = 0;
      if (hs) begin
        err_m = l_e ? (beat_m != q[0].len) : (beat_m == q[0].len);
        if (l_e) begin
          void'(q.pop_front());
          beat_m = 0;
        end else begin
          beat_m = (beat_m + 1) % 256;
        end
      end
      if (areq && agnt && !full_e) q.push_back('{asel, alen});
    end
  endtask

  initial begin
    bit     do_r, last_ok;
    logic [NM-1:0] wv, wl;
    // reset state
    cycle(1, 0, 0, 0, 0, '0, '0, 0);
    cycle(0, 0, 0, 0, 0, '0, '0, 1);

    // single burst: master 2, len 3
    cycle(0, 1, 2, 3, 1, '0, '0, 1);
    for (int b = 0; b < 4; b++) cycle(0, 0, 0, 0, 0, 5'b00100, (b == 3) ? 5'b00100 : 5'b0, 1);
    cycle(0, 0, 0, 0, 0, 5'b00100, '0, 1);

    // ordering 1,3,0 with all masters valid and last
    cycle(0, 1, 1, 0, 1, '0, '0, 1);
    cycle(0, 1, 3, 0, 1, 5'b11111, 5'b11111, 0);
    cycle(0, 1, 0, 0, 1, 5'b11111, 5'b11111, 0);
    for (int b = 0; b < 4; b++) cycle(0, 0, 0, 0, 0, 5'b11111, 5'b11111, 1);

    // full: four AWs, fifth blocked, one pop lets it in next cycle
    for (int k = 0; k < 4; k++) cycle(0, 1, k, 0, 1, '0, '0, 1);
    cycle(0, 1, 4, 0, 1, '0, '0, 1);
    cycle(0, 1, 4, 0, 1, 5'b00001, 5'b00001, 1);
    cycle(0, 1, 4, 0, 1, '0, '0, 1);
    for (int k = 0; k < 6; k++) cycle(0, 0, 0, 0, 0, 5'b11111, 5'b11111, 1);

    // early WLAST on len=1, then missing WLAST on len=0
    cycle(0, 1, 3, 1, 1, '0, '0, 1);
    cycle(0, 0, 0, 0, 0, 5'b01000, 5'b01000, 1);
    cycle(0, 1, 3, 0, 1, '0, '0, 1);
    cycle(0, 0, 0, 0, 0, 5'b01000, 5'b00000, 1);
    cycle(0, 0, 0, 0, 0, 5'b01000, 5'b00000, 1);
    cycle(0, 0, 0, 0, 0, 5'b01000, 5'b01000, 1);
    cycle(0, 0, 0, 0, 0, '0, '0, 1);

    // W before AW on master 4
    cycle(0, 0, 0, 0, 0, 5'b10000, 5'b10000, 1);
    cycle(0, 0, 0, 0, 0, 5'b10000, 5'b10000, 1);
    cycle(0, 1, 4, 0, 1, 5'b10000, 5'b10000, 1);
    cycle(0, 0, 0, 0, 0, 5'b10000, 5'b10000, 1);

    // mid-burst reset after 2 of 4 beats, then a len=0 burst must not flag
    cycle(0, 1, 2, 3, 1, '0, '0, 1);
    cycle(0, 0, 0, 0, 0, 5'b00100, '0, 1);
    cycle(0, 0, 0, 0, 0, 5'b00100, '0, 1);
    cycle(1, 0, 0, 0, 0, 5'b00100, '0, 1);
    cycle(0, 0, 0, 0, 0, 5'b00100, '0, 1);
    cycle(0, 1, 2, 0, 1, '0, '0, 1);
    cycle(0, 0, 0, 0, 0, 5'b00100, 5'b00100, 1);
    cycle(0, 0, 0, 0, 0, '0, '0, 1);

    // randomized traffic; WLAST mostly honest for the head master
    for (int c = 0; c < 4000; c++) begin
      wv = NM'($urandom);
      wl = NM'($urandom);
      if (q.size() != 0) begin
        last_ok = (beat_m == q[0].len);
        wl[q[0].sel] = last_ok ^ ($urandom_range(0, 19) == 0);
      end
      do_r = ($urandom_range(0, 599) == 0);
      cycle(do_r, $urandom_range(0, 1), $urandom_range(0, NM - 1), $urandom_range(0, 3),
            $urandom_range(0, 3) != 0, wv, wl, $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
